// File: rtl/adc3664_spi_master.sv
// adc3664_spi_master: command/response master for the ADC3664 3-wire SPI register port.
// One command becomes one 24-bit frame {rw, 3'b000, addr, data}; reads return the last 8 bits from SDIO.
module adc3664_spi_master #(
  parameter int CLK_DIV   = 2,
  parameter int SEN_SETUP = 2,
  parameter int SEN_HOLD  = 2,
  parameter int GAP       = 4
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [11:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        SCLK,
  output logic        SEN,
  inout  wire         SDIO
);
  localparam int M1   = (2 * CLK_DIV > SEN_SETUP) ? 2 * CLK_DIV : SEN_SETUP;
  localparam int M2   = (M1 > SEN_HOLD) ? M1 : SEN_HOLD;
  localparam int MAXC = (M2 > GAP) ? M2 : GAP;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] SETUP_END = CW'(SEN_SETUP - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HI_START  = CW'(CLK_DIV);
  localparam logic [CW-1:0] HOLD_END  = CW'(SEN_HOLD - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     bit_q, bit_d;
  logic [23:0]    frame_q, frame_d;
  logic [7:0]     rd_q, rd_d, rsp_rdata_q, rsp_rdata_d;
  logic           rw_q, rw_d, samp_q, samp_d;
  logic           cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;
  logic           sclk_q, sclk_d, sen_q, sen_d, sdo_q, sdo_d, oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    frame_d = frame_q;
    rw_d    = rw_q;
    rd_d    = samp_q ? {rd_q[6:0], SDIO} : rd_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          state_d = S_SETUP;
          rw_d    = cmd_rw;
          frame_d = {cmd_rw, 3'b000, cmd_addr, cmd_rw ? 8'h00 : cmd_wdata};
          rd_d    = '0;
        end
      end
      S_SETUP: if (cnt_q == SETUP_END) begin
        state_d = S_SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
      end
      S_SHIFT: if (cnt_q == SLOT_END) begin
        cnt_d   = '0;
        bit_d   = bit_q + 1'b1;
        frame_d = {frame_q[22:0], 1'b0};
        if (bit_q == 5'd23) state_d = S_HOLD;
      end
      S_HOLD: if (cnt_q == HOLD_END) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      default: if (cnt_q == GAP_END) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin registers follow the current state, so every pin lags the FSM by exactly one cycle.
  always_comb begin
    sen_d       = !(state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD);
    sclk_d      = state_q == S_SHIFT && cnt_q >= HI_START;
    oe_d        = state_q == S_SETUP || (state_q == S_SHIFT && !(rw_q && bit_q[4]));
    sdo_d       = frame_q[23];
    samp_d      = state_q == S_SHIFT && rw_q && bit_q[4] && cnt_q == SLOT_END;
    rsp_valid_d = state_q == S_GAP && cnt_q == '0;
    rsp_rdata_d = rsp_valid_d ? (rw_q ? rd_q : 8'h00) : rsp_rdata_q;
    cmd_ready_d = state_d == S_IDLE;
    busy_d      = state_d != S_IDLE;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      rw_q        <= 1'b0;
      rd_q        <= '0;
      samp_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      sclk_q      <= 1'b0;
      sen_q       <= 1'b1;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      rw_q        <= rw_d;
      rd_q        <= rd_d;
      samp_q      <= samp_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      sclk_q      <= sclk_d;
      sen_q       <= sen_d;
      sdo_q       <= sdo_d;
      oe_q        <= oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SCLK      = sclk_q;
  assign SEN       = sen_q;
  assign SDIO      = oe_q ? sdo_q : 1'bz;
endmodule
